// File: rtl/mpe_accum.sv
// Weight-stationary-free convolution PE: latches an input tile, streams kernel weights,
// accumulates strided products per output lane. Optional saturation via MPE_ACCUM_SAT_EN.
module mpe_accum #(
    parameter int BIN_LEN     = 8,
    parameter int OUT_BIN_LEN = 24,
    parameter int IN_H        = 6,
    parameter int IN_W        = 6,
    parameter int OUT_H       = 4,
    parameter int OUT_W       = 4,
    parameter int KERNEL_H    = 3,
    parameter int KERNEL_W    = 3
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic                                  in_load,
    input  logic [IN_H*IN_W*BIN_LEN-1:0]          in_vals,
    input  logic [2:0]                            stride,
    input  logic                                  w_valid,
    output logic                                  w_ready,
    input  logic [BIN_LEN-1:0]                    w_val,
    input  logic                                  w_abs,
    input  logic [$clog2(KERNEL_H)-1:0]           w_height,
    input  logic [$clog2(KERNEL_W)-1:0]           w_width,
    input  logic                                  w_last,
    output logic [OUT_H*OUT_W*OUT_BIN_LEN-1:0]    out_vals,
    output logic                                  out_valid,
    input  logic                                  out_ready
`ifdef MPE_ACCUM_SAT_EN
    ,
    output logic                                  sat_flag
`endif
);

    localparam int WE_W   = BIN_LEN + 1;
    localparam int IDX_W  = 16;
    localparam int PROD_W = 2 * BIN_LEN + 1;
    localparam int SUM_W  = ((PROD_W > OUT_BIN_LEN) ? PROD_W : OUT_BIN_LEN) + 1;

    typedef enum logic [1:0] {IDLE, ACC, DRAIN, OUT} state_t;

    state_t state_q, state_d;
    logic   drain_q;
    logic   load, accept;

    logic signed [BIN_LEN-1:0]     win_q [IN_H][IN_W];
    logic [2:0]                    stride_q;
    logic signed [WE_W-1:0]        w_eff_q, w_eff_d;
    logic signed [BIN_LEN-1:0]     sel_d [OUT_H][OUT_W];

    logic                          vld_p1;
    logic signed [WE_W-1:0]        w_p1;
    logic signed [BIN_LEN-1:0]     sel_p1 [OUT_H][OUT_W];
    logic signed [OUT_BIN_LEN-1:0] acc_p2 [OUT_H][OUT_W];
    logic signed [OUT_BIN_LEN-1:0] acc_d  [OUT_H][OUT_W];

`ifdef MPE_ACCUM_SAT_EN
    localparam logic signed [SUM_W-1:0] ACC_MAX =
        {{(SUM_W-OUT_BIN_LEN+1){1'b0}}, {(OUT_BIN_LEN-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] ACC_MIN =
        {{(SUM_W-OUT_BIN_LEN+1){1'b1}}, {(OUT_BIN_LEN-1){1'b0}}};
    logic clip_any;

    function automatic logic is_clip(input logic signed [SUM_W-1:0] s);
        return (s > ACC_MAX) || (s < ACC_MIN);
    endfunction
`endif

    function automatic logic signed [OUT_BIN_LEN-1:0] fit_acc(input logic signed [SUM_W-1:0] s);
`ifdef MPE_ACCUM_SAT_EN
        if (s > ACC_MAX) return ACC_MAX[OUT_BIN_LEN-1:0];
        if (s < ACC_MIN) return ACC_MIN[OUT_BIN_LEN-1:0];
`endif
        return s[OUT_BIN_LEN-1:0];
    endfunction

    assign load      = (state_q == IDLE) && in_load;
    assign accept    = (state_q == ACC) && w_valid;
    assign w_ready   = (state_q == ACC);
    assign out_valid = (state_q == OUT);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            drain_q <= 1'b0;
        end else begin
            state_q <= state_d;
            drain_q <= (state_q == DRAIN) ? ~drain_q : 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_load) state_d = ACC;
            ACC:     if (w_valid && w_last) state_d = DRAIN;
            DRAIN:   if (drain_q) state_d = OUT;
            OUT:     if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A delta wraps in BIN_LEN+1 bits; an absolute weight replaces W outright.
    always_comb begin
        w_eff_d = w_abs ? WE_W'(signed'(w_val)) : w_eff_q + WE_W'(signed'(w_val));
    end

    always_comb begin
        logic [IDX_W-1:0] row, col;
        row = '0;
        col = '0;
        for (int i = 0; i < OUT_H; i++) begin
            for (int j = 0; j < OUT_W; j++) begin
                sel_d[i][j] = '0;
                row = IDX_W'(i) * IDX_W'(stride_q) + IDX_W'(w_height);
                col = IDX_W'(j) * IDX_W'(stride_q) + IDX_W'(w_width);
                for (int r = 0; r < IN_H; r++)
                    for (int c = 0; c < IN_W; c++)
                        if (row == IDX_W'(r) && col == IDX_W'(c))
                            sel_d[i][j] = win_q[r][c];
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stride_q <= 3'd0;
            w_eff_q  <= '0;
            for (int r = 0; r < IN_H; r++)
                for (int c = 0; c < IN_W; c++)
                    win_q[r][c] <= '0;
        end else if (load) begin
            stride_q <= (stride == 3'd0) ? 3'd1 : stride;
            w_eff_q  <= '0;
            for (int r = 0; r < IN_H; r++)
                for (int c = 0; c < IN_W; c++)
                    win_q[r][c] <= in_vals[(r*IN_W+c)*BIN_LEN +: BIN_LEN];
        end else if (accept) begin
            w_eff_q <= w_eff_d;
        end
    end

    // Stage 1: register effective weight and the strided operand for every lane.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            vld_p1 <= 1'b0;
            w_p1   <= '0;
            for (int i = 0; i < OUT_H; i++)
                for (int j = 0; j < OUT_W; j++)
                    sel_p1[i][j] <= '0;
        end else begin
            vld_p1 <= accept;
            if (accept) begin
                w_p1 <= w_eff_d;
                for (int i = 0; i < OUT_H; i++)
                    for (int j = 0; j < OUT_W; j++)
                        sel_p1[i][j] <= sel_d[i][j];
            end
        end
    end

    always_comb begin
        logic signed [PROD_W-1:0] prod;
        logic signed [SUM_W-1:0]  sum;
        prod = '0;
        sum  = '0;
`ifdef MPE_ACCUM_SAT_EN
        clip_any = 1'b0;
`endif
        for (int i = 0; i < OUT_H; i++) begin
            for (int j = 0; j < OUT_W; j++) begin
                prod = PROD_W'(w_p1) * PROD_W'(sel_p1[i][j]);
                sum  = SUM_W'(acc_p2[i][j]) + SUM_W'(prod);
                acc_d[i][j] = fit_acc(sum);
`ifdef MPE_ACCUM_SAT_EN
                clip_any = clip_any | is_clip(sum);
`endif
            end
        end
    end

    // Stage 2: accumulate; tiles are cleared only by the next load.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < OUT_H; i++)
                for (int j = 0; j < OUT_W; j++)
                    acc_p2[i][j] <= '0;
        end else if (load) begin
            for (int i = 0; i < OUT_H; i++)
                for (int j = 0; j < OUT_W; j++)
                    acc_p2[i][j] <= '0;
        end else if (vld_p1) begin
            for (int i = 0; i < OUT_H; i++)
                for (int j = 0; j < OUT_W; j++)
                    acc_p2[i][j] <= acc_d[i][j];
        end
    end

`ifdef MPE_ACCUM_SAT_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)                 sat_flag <= 1'b0;
        else if (load)              sat_flag <= 1'b0;
        else if (vld_p1 && clip_any) sat_flag <= 1'b1;
    end
`endif

    always_comb begin
        out_vals = '0;
        for (int i = 0; i < OUT_H; i++)
            for (int j = 0; j < OUT_W; j++)
                out_vals[(i*OUT_W+j)*OUT_BIN_LEN +: OUT_BIN_LEN] = acc_p2[i][j];
    end

endmodule

// File: tb/tb_mpe_accum.sv
// Bench for mpe_accum: directed tiles plus randomized tiles against a plain-arithmetic
// convolution model. Saturation expectations follow MPE_ACCUM_SAT_EN.
module tb_mpe_accum;

    localparam int BIN_LEN     = 8;
    localparam int OUT_BIN_LEN = 16;
    localparam int IN_H = 6, IN_W = 6, OUT_H = 4, OUT_W = 4;
    localparam int KERNEL_H = 3, KERNEL_W = 3;
    localparam int HW = $clog2(KERNEL_H);
    localparam int WW = $clog2(KERNEL_W);

    logic clock, reset, in_load, w_valid, w_ready, w_abs, w_last, out_valid, out_ready;
    logic [IN_H*IN_W*BIN_LEN-1:0]       in_vals;
    logic [2:0]                         stride;
    logic [BIN_LEN-1:0]                 w_val;
    logic [HW-1:0]                      w_height;
    logic [WW-1:0]                      w_width;
    logic [OUT_H*OUT_W*OUT_BIN_LEN-1:0] out_vals;
`ifdef MPE_ACCUM_SAT_EN
    logic sat_flag;
`endif

    mpe_accum #(
        .BIN_LEN(BIN_LEN), .OUT_BIN_LEN(OUT_BIN_LEN), .IN_H(IN_H), .IN_W(IN_W),
        .OUT_H(OUT_H), .OUT_W(OUT_W), .KERNEL_H(KERNEL_H), .KERNEL_W(KERNEL_W)
    ) dut (
        .clock(clock), .reset(reset), .in_load(in_load), .in_vals(in_vals),
        .stride(stride), .w_valid(w_valid), .w_ready(w_ready), .w_val(w_val),
        .w_abs(w_abs), .w_height(w_height), .w_width(w_width), .w_last(w_last),
        .out_vals(out_vals), .out_valid(out_valid), .out_ready(out_ready)
`ifdef MPE_ACCUM_SAT_EN
        , .sat_flag(sat_flag)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    typedef struct { int val; bit abs_f; int h; int w; } beat_t;
    beat_t  beats[$];
    int     win_m [IN_H][IN_W];
    int     stride_m;
    longint exp_acc [OUT_H][OUT_W];
    bit     exp_sat;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint wrap_to(longint x, int n);
        longint m = longint'(1) << n;
        longint r = x % m;
        if (r < 0) r += m;
        if (r >= m / 2) r -= m;
        return r;
    endfunction

    // Reference: direct convolution sum, one kernel tap per beat.
    function automatic void model_tile();
        longint weff = 0;
        int s = (stride_m == 0) ? 1 : stride_m;
        exp_sat = 1'b0;
        for (int i = 0; i < OUT_H; i++)
            for (int j = 0; j < OUT_W; j++)
                exp_acc[i][j] = 0;
        for (int k = 0; k < beats.size(); k++) begin
            weff = beats[k].abs_f ? longint'(beats[k].val)
                                  : wrap_to(weff + beats[k].val, BIN_LEN + 1);
            for (int i = 0; i < OUT_H; i++) begin
                for (int j = 0; j < OUT_W; j++) begin
                    int r = i * s + beats[k].h;
                    int c = j * s + beats[k].w;
                    longint x = (r < IN_H && c < IN_W) ? longint'(win_m[r][c]) : 0;
                    longint sum = exp_acc[i][j] + weff * x;
`ifdef MPE_ACCUM_SAT_EN
                    longint hi = (longint'(1) << (OUT_BIN_LEN - 1)) - 1;
                    longint lo = -(longint'(1) << (OUT_BIN_LEN - 1));
                    if (sum > hi) begin sum = hi; exp_sat = 1'b1; end
                    if (sum < lo) begin sum = lo; exp_sat = 1'b1; end
                    exp_acc[i][j] = sum;
`else
                    exp_acc[i][j] = wrap_to(sum, OUT_BIN_LEN);
`endif
                end
            end
        end
    endfunction

    function automatic logic [OUT_BIN_LEN-1:0] lane(int i, int j);
        return out_vals[(i*OUT_W+j)*OUT_BIN_LEN +: OUT_BIN_LEN];
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic load_tile();
        for (int r = 0; r < IN_H; r++)
            for (int c = 0; c < IN_W; c++)
                in_vals[(r*IN_W+c)*BIN_LEN +: BIN_LEN] = BIN_LEN'(win_m[r][c]);
        stride  = 3'(stride_m);
        in_load = 1'b1;
        tick();
        in_load = 1'b0;
        chk("ready_after_load", 32'(w_ready), 32'd1);
    endtask

    task automatic send_beats(input int gap_max);
        for (int k = 0; k < beats.size(); k++) begin
            int gap = (gap_max > 0) ? $urandom_range(gap_max, 0) : 0;
            w_valid = 1'b0;
            repeat (gap) tick();
            w_valid  = 1'b1;
            w_val    = BIN_LEN'(beats[k].val);
            w_abs    = beats[k].abs_f;
            w_height = HW'(beats[k].h);
            w_width  = WW'(beats[k].w);
            w_last   = (k == beats.size() - 1);
            tick();
        end
        w_valid = 1'b0;
        w_last  = 1'b0;
    endtask

    task automatic wait_out(input string tag);
        int n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_latency"}, 32'(n), 32'd2);
    endtask

    task automatic chk_lanes(input string tag);
        model_tile();
        for (int i = 0; i < OUT_H; i++)
            for (int j = 0; j < OUT_W; j++) begin
                logic [OUT_BIN_LEN-1:0] e;
                e = OUT_BIN_LEN'(exp_acc[i][j]);
                chk($sformatf("%s_lane%0d_%0d", tag, i, j), 32'(lane(i, j)), 32'(e));
            end
`ifdef MPE_ACCUM_SAT_EN
        chk({tag, "_sat_flag"}, 32'(sat_flag), 32'(exp_sat));
`endif
    endtask

    task automatic finish_tile(input int hold);
        for (int k = 0; k < hold; k++) begin
            chk("out_hold_valid", 32'(out_valid), 32'd1);
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("out_drop", 32'(out_valid), 32'd0);
    endtask

    function automatic void fill_win(input int v);
        for (int r = 0; r < IN_H; r++)
            for (int c = 0; c < IN_W; c++)
                win_m[r][c] = v;
    endfunction

    function automatic void add_beat(int v, bit a, int h, int w);
        beat_t b;
        b.val = v; b.abs_f = a; b.h = h; b.w = w;
        beats.push_back(b);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [OUT_H*OUT_W*OUT_BIN_LEN-1:0] snap;
        reset = 1'b1; in_load = 0; in_vals = '0; stride = 0; w_valid = 0;
        w_val = 0; w_abs = 0; w_height = 0; w_width = 0; w_last = 0; out_ready = 0;
        #1 reset = 1'b0;
        repeat (3) tick();
        chk("reset_w_ready", 32'(w_ready), 32'd0);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_out_vals", 32'(|out_vals), 32'd0);
        reset = 1'b1;
        tick();

        // All-ones window, nine taps of weight 2.
        fill_win(1); stride_m = 1; beats.delete();
        for (int h = 0; h < 3; h++)
            for (int w = 0; w < 3; w++)
                add_beat(2, 1'b1, h, w);
        load_tile();
        send_beats(0);
        wait_out("ones");
        chk_lanes("ones");
        chk("ones_const", 32'(lane(3, 3)), 32'd18);
        finish_tile(0);

        // Ramp window, stride 2, single tap at (1,1).
        for (int r = 0; r < IN_H; r++)
            for (int c = 0; c < IN_W; c++)
                win_m[r][c] = r * IN_W + c;
        stride_m = 2; beats.delete();
        add_beat(1, 1'b1, 1, 1);
        load_tile();
        send_beats(0);
        wait_out("stride2");
        chk_lanes("stride2");
        chk("stride2_00", 32'(lane(0, 0)), 32'd7);
        chk("stride2_11", 32'(lane(1, 1)), 32'd21);
        chk("stride2_22", 32'(lane(2, 2)), 32'd35);
        chk("stride2_33", 32'(lane(3, 3)), 32'd0);
        finish_tile(1);

        // Delta stream 5, -3, +1; then backpressure with in_load held.
        fill_win(1); stride_m = 1; beats.delete();
        add_beat(5, 1'b1, 0, 0);
        add_beat(-3, 1'b0, 1, 1);
        add_beat(1, 1'b0, 2, 2);
        load_tile();
        send_beats(0);
        wait_out("delta");
        chk_lanes("delta");
        chk("delta_const", 32'(lane(1, 2)), 32'd10);
        snap = out_vals;
        in_load = 1'b1;
        in_vals = {IN_H*IN_W{8'h55}};
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("bp_vals_stable", 32'(out_vals === snap), 32'd1);
            chk("bp_w_ready", 32'(w_ready), 32'd0);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
        end
        in_load = 1'b0;
        finish_tile(0);
        chk("acc_kept_idle", 32'(out_vals === snap), 32'd1);
        fill_win(3); stride_m = 0; beats.delete();
        add_beat(-2, 1'b1, 0, 0);
        load_tile();
        chk("fresh_acc_zero", 32'(|out_vals), 32'd0);
        send_beats(0);
        wait_out("fresh");
        chk_lanes("fresh");
        finish_tile(0);

        // Large operands: wraps or clips depending on build.
        fill_win(127); stride_m = 1; beats.delete();
        for (int h = 0; h < 3; h++)
            for (int w = 0; w < 3; w++)
                add_beat(127, 1'b1, h, w);
        load_tile();
        send_beats(0);
        wait_out("big");
        chk_lanes("big");
`ifdef MPE_ACCUM_SAT_EN
        chk("big_sat_const", 32'(lane(0, 0)), 32'd32767);
`endif
        finish_tile(0);

        // Reset during accumulation aborts the tile asynchronously.
        fill_win(4); stride_m = 1; beats.delete();
        load_tile();
        w_valid = 1'b1; w_val = 8'd9; w_abs = 1'b1; w_last = 1'b0;
        repeat (3) tick();
        #2 reset = 1'b0;
        #1;
        chk("midrst_w_ready", 32'(w_ready), 32'd0);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_out_vals", 32'(|out_vals), 32'd0);
        w_valid = 1'b0;
        tick();
        reset = 1'b1;
        repeat (4) tick();
        chk("midrst_idle_ready", 32'(w_ready), 32'd0);
        chk("midrst_no_valid", 32'(out_valid), 32'd0);

        // Randomized tiles with gaps, backpressure and early out_ready.
        for (int t = 0; t < 20; t++) begin
            bit early;
            for (int r = 0; r < IN_H; r++)
                for (int c = 0; c < IN_W; c++)
                    win_m[r][c] = int'($urandom_range(255, 0)) - 128;
            stride_m = $urandom_range(7, 0);
            beats.delete();
            for (int k = 0; k < int'($urandom_range(10, 1)); k++)
                add_beat(int'($urandom_range(255, 0)) - 128, 1'($urandom_range(1, 0)),
                         $urandom_range(3, 0), $urandom_range(3, 0));
            early = 1'($urandom_range(1, 0));
            load_tile();
            out_ready = early;
            send_beats(2);
            wait_out($sformatf("rnd%0d", t));
            chk_lanes($sformatf("rnd%0d", t));
            finish_tile(early ? 0 : $urandom_range(3, 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
